oup_ulpi_regctrl: RTL

OUP_ULPI_REGCTRL -- requirements
Module: oup_ulpi_regctrl

---
 rtl/oup_ulpi_regctrl_if.sv | 40 ++++
 rtl/oup_ulpi_regctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/oup_ulpi_regctrl_if.sv
// rtl/oup_ulpi_regctrl_if.sv - requester and ULPI link signal bundle for the register controller
//
// Purpose: groups the two-port requester handshake, the completion response and
// the link side of the ULPI bus so they travel as one port.
// Ports (signals):
//   req_valid_i[1:0], req_write_i[1:0], req_addr_i[15:0], req_wdata_i[15:0]
//                       : per-requester request, byte lane p belongs to requester p
//   req_ready_o[1:0]    : one-cycle accept pulse to the granted requester
//   rsp_valid_o[1:0], rsp_rdata_o[7:0], rsp_err_o : completion to the owning requester
//   ulpi_data_i/o[7:0], ulpi_dir_i, ulpi_stp_o, ulpi_nxt_i : ULPI link side
// Modports: slave = the controller, master = requesters plus PHY.
interface oup_ulpi_regctrl_if;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_write_i;
  logic [15:0] req_addr_i;
  logic [15:0] req_wdata_i;
  logic [1:0]  rsp_valid_o;
  logic [7:0]  rsp_rdata_o;
  logic        rsp_err_o;
  logic [7:0]  ulpi_data_i;
  logic [7:0]  ulpi_data_o;
  logic        ulpi_dir_i;
  logic        ulpi_stp_o;
  logic        ulpi_nxt_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    input  ulpi_data_i, ulpi_dir_i, ulpi_nxt_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output ulpi_data_o, ulpi_stp_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    output ulpi_data_i, ulpi_dir_i, ulpi_nxt_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  ulpi_data_o, ulpi_stp_o
  );
endinterface

// File: rtl/oup_ulpi_regctrl.sv
// rtl/oup_ulpi_regctrl.sv - two-requester ULPI PHY register read/write controller
//
// Purpose: arbitrates two register requesters round-robin and runs one ULPI
// register transaction at a time (immediate or extended address, read or write),
// with abort/retry when the PHY takes the bus and a nxt-wait timeout.
// Ports:
//   clk_i : ULPI clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : oup_ulpi_regctrl_if.slave (requests, responses, ULPI link side)
// Parameter NXT_TIMEOUT: PHY-wait cycles before a transaction is abandoned.
module oup_ulpi_regctrl #(
  parameter int NXT_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  oup_ulpi_regctrl_if.slave    bus
);

  localparam int CW = $clog2(NXT_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_EXTADDR, S_WDATA, S_STOP,
    S_RD_TURN, S_RD_DATA, S_RD_END, S_DONE, S_RETRY
  } state_t;

  state_t        state, state_d;
  logic          rr_ptr;
  logic          owner;
  logic          cap_write;
  logic [7:0]    cap_addr;
  logic [7:0]    cap_wdata;
  logic [CW-1:0] cnt;
  logic [1:0]    rsp_valid_q;
  logic          rsp_err_q;
  logic [7:0]    rsp_rdata_q;

  logic          grant_sel;
  logic          accept;
  logic          cap_ext;
  logic          counting;
  logic          timed_out;
  logic [7:0]    cmd_byte;
  logic [7:0]    data_d;
  logic [1:0]    owner_onehot;

  // With both ports valid the pointer decides; otherwise the lone valid port wins.
  assign grant_sel = (bus.req_valid_i == 2'b11) ? rr_ptr : bus.req_valid_i[1];
  assign accept    = (state == S_IDLE) && !bus.ulpi_dir_i && (|bus.req_valid_i) && !rst_i;

  // Address 0x2F is the extended-register escape code itself, so it cannot be sent immediately.
  assign cap_ext  = (cap_addr > 8'h3F) || (cap_addr == 8'h2F);
  assign cmd_byte = {cap_write ? 2'b10 : 2'b11, cap_ext ? 6'b101111 : cap_addr[5:0]};

  assign owner_onehot = owner ? 2'b10 : 2'b01;

  assign counting = (state == S_CMD) || (state == S_EXTADDR) ||
                    (state == S_WDATA) || (state == S_RD_TURN);
  // Timeout only when the cycle makes no other progress (no dir takeover, no nxt).
  assign timed_out = counting && !bus.ulpi_dir_i && !bus.ulpi_nxt_i &&
                     (cnt == CW'(NXT_TIMEOUT - 1));

  always_comb begin
    state_d = state;
    data_d  = 8'h00;
    case (state)
      S_IDLE: begin
        if (accept) state_d = S_CMD;
      end
      S_CMD: begin
        data_d = cmd_byte;
        if (bus.ulpi_dir_i)      state_d = S_RETRY;
        else if (bus.ulpi_nxt_i) state_d = cap_ext ? S_EXTADDR : (cap_write ? S_WDATA : S_RD_TURN);
        else if (timed_out)      state_d = S_IDLE;
      end
      S_EXTADDR: begin
        data_d = cap_addr;
        if (bus.ulpi_dir_i)      state_d = S_RETRY;
        else if (bus.ulpi_nxt_i) state_d = cap_write ? S_WDATA : S_RD_TURN;
        else if (timed_out)      state_d = S_IDLE;
      end
      S_WDATA: begin
        data_d = cap_wdata;
        if (bus.ulpi_dir_i)      state_d = S_RETRY;
        else if (bus.ulpi_nxt_i) state_d = S_STOP;
        else if (timed_out)      state_d = S_IDLE;
      end
      S_STOP: begin
        state_d = S_DONE;
      end
      S_RD_TURN: begin
        if (bus.ulpi_dir_i)  state_d = S_RD_DATA;
        else if (timed_out)  state_d = S_IDLE;
      end
      S_RD_DATA: begin
        state_d = S_RD_END;
      end
      S_RD_END: begin
        if (!bus.ulpi_dir_i) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_RETRY: begin
        if (!bus.ulpi_dir_i) state_d = S_CMD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // The PHY owns the data lines whenever dir is high.
    if (bus.ulpi_dir_i) data_d = 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      cap_write   <= 1'b0;
      cap_addr    <= 8'h00;
      cap_wdata   <= 8'h00;
      cnt         <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state       <= state_d;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      // Counter restarts on any state change and whenever the PHY signals nxt.
      if ((state_d != state) || bus.ulpi_nxt_i || !counting) cnt <= '0;
      else                                                   cnt <= cnt + 1'b1;
      if (accept) begin
        owner     <= grant_sel;
        cap_write <= bus.req_write_i[grant_sel];
        cap_addr  <= bus.req_addr_i[{grant_sel, 3'b000} +: 8];
        cap_wdata <= bus.req_wdata_i[{grant_sel, 3'b000} +: 8];
        rr_ptr    <= ~grant_sel;
      end
      if (state == S_RD_DATA) rsp_rdata_q <= bus.ulpi_data_i;
      // Completion pulse is registered so it lines up with the DONE cycle.
      if (timed_out) begin
        rsp_valid_q <= owner_onehot;
        rsp_err_q   <= 1'b1;
      end else if (state_d == S_DONE) begin
        rsp_valid_q <= owner_onehot;
      end
    end
  end

  assign bus.req_ready_o = accept ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.ulpi_data_o = data_d;
  assign bus.ulpi_stp_o  = (state == S_STOP);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule
